riscv_result_checker: RTL

RISCV_RESULT_CHECKER -- requirements
Module: riscv_result_checker

---
 rtl/riscv_chk_pkg.sv | 28 ++
 rtl/riscv_chk_table.sv | 109 ++++++++++
 rtl/riscv_result_checker.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_chk_pkg.sv
// -----------------------------------------------------------------------------
// riscv_chk_pkg
// Shared definitions for the RISC-V result checker: the checker state
// encoding, default table size and timeout, the FAIL_IDX code reserved for a
// timeout, and a saturating increment used by the RUN cycle counter.
// -----------------------------------------------------------------------------
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  // The table index is 6 bits wide and 6'h3F is reserved for the timeout
  // code, so a table may hold at most 63 entries.
  localparam int          NUM_TEST_DEFAULT = 40;
  localparam logic [31:0] TIMEOUT_DEFAULT  = 32'd1000000;
  localparam logic [5:0]  FAIL_IDX_TIMEOUT = 6'h3F;
  localparam logic [31:0] CYCLE_MAX        = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == CYCLE_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/riscv_chk_table.sv
// -----------------------------------------------------------------------------
// riscv_chk_table
// Expected-result table for the result checker. Each entry holds a trigger
// instruction count, the expected output value, a valid bit and a passed bit.
// While checking is enabled, every valid, not-yet-passed entry whose trigger
// count equals the current retired-instruction count is compared against the
// core output in the same cycle.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wrEn_i               write strobe (already qualified by the caller)
//   wrIdx_i              entry to write
//   wrNumInst_i/wrAns_i  trigger count and expected value for the entry
//   clrPassed_i          clear every passed bit (start of a run)
//   chkEn_i              compare enable (RUN state)
//   numInst_i            retired-instruction count from the core
//   outValue_i           core output value under check
//   mismatch_o           at least one triggered entry disagrees
//   mismatchIdx_o        lowest disagreeing entry index
//   matchCnt_o           number of triggered entries that agree
// -----------------------------------------------------------------------------
module riscv_chk_table
  import riscv_chk_pkg::*;
#(
  parameter int NUM_TEST = NUM_TEST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wrEn_i,
  input  logic [5:0]  wrIdx_i,
  input  logic [31:0] wrNumInst_i,
  input  logic [31:0] wrAns_i,
  input  logic        clrPassed_i,
  input  logic        chkEn_i,
  input  logic [31:0] numInst_i,
  input  logic [31:0] outValue_i,
  output logic        mismatch_o,
  output logic [5:0]  mismatchIdx_o,
  output logic [5:0]  matchCnt_o
);

  logic [31:0]         numInst_q [NUM_TEST];
  logic [31:0]         ans_q     [NUM_TEST];
  logic [NUM_TEST-1:0] valid_q;
  logic [NUM_TEST-1:0] passed_q;

  logic [NUM_TEST-1:0] matchVec;
  logic [NUM_TEST-1:0] badVec;

  // Classify every entry triggered this cycle as a match or a mismatch.
  // Passed entries are excluded so that they are never re-checked in a run.
  always_comb begin
    matchVec = '0;
    badVec   = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      if (chkEn_i && valid_q[i] && !passed_q[i] && (numInst_q[i] == numInst_i)) begin
        matchVec[i] = (ans_q[i] == outValue_i);
        badVec[i]   = (ans_q[i] != outValue_i);
      end
    end
  end

  assign mismatch_o = |badVec;

  // Priority encoder: scanning downward leaves the lowest failing index.
  always_comb begin
    mismatchIdx_o = '0;
    for (int i = NUM_TEST - 1; i >= 0; i--) begin
      if (badVec[i]) begin
        mismatchIdx_o = 6'(i);
      end
    end
  end

  // Population count of the entries that matched this cycle.
  always_comb begin
    matchCnt_o = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      matchCnt_o = matchCnt_o + {5'd0, matchVec[i]};
    end
  end

  // Table storage. A cycle with any mismatch commits no passed bits, because
  // the run ends in FAIL and the partial results of that cycle are discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        numInst_q[i] <= '0;
        ans_q[i]     <= '0;
      end
      valid_q  <= '0;
      passed_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TEST; i++) begin
        if (wrEn_i && (wrIdx_i == 6'(i))) begin
          numInst_q[i] <= wrNumInst_i;
          ans_q[i]     <= wrAns_i;
          valid_q[i]   <= 1'b1;
        end
      end
      if (clrPassed_i) begin
        passed_q <= '0;
      end else if (chkEn_i && !mismatch_o) begin
        passed_q <= passed_q | matchVec;
      end
    end
  end

endmodule

// File: rtl/riscv_result_checker.sv
// -----------------------------------------------------------------------------
// riscv_result_checker
// Watches a RISC-V core while it runs a test program and compares its output
// port against a preloaded table of (instruction count, expected value) pairs.
// The checker ends in PASS when the core halts without any disagreement and in
// FAIL on the first disagreement or when the RUN cycle budget is exhausted.
//
// Ports
//   CLK, RSTn                    clock, asynchronous active-low reset
//   NUM_INST, OUTPUT_PORT, HALT  core status under observation
//   CFG_WE, CFG_IDX,
//   CFG_NUM_INST, CFG_ANS        table write port (honoured only in IDLE)
//   START                        begin a run from IDLE
//   CLEAR                        leave PASS/FAIL for IDLE
//   STATE                        IDLE=0, RUN=1, PASS=2, FAIL=3
//   FAIL_IDX, FAIL_VALUE         first failing entry (6'h3F = timeout), value
//   PASS_CNT                     entries passed in the current run
//   CYCLE                        RUN cycle counter
// -----------------------------------------------------------------------------
module riscv_result_checker
  import riscv_chk_pkg::*;
#(
  parameter int          NUM_TEST = NUM_TEST_DEFAULT,
  parameter logic [31:0] TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] NUM_INST,
  input  logic [31:0] OUTPUT_PORT,
  input  logic        HALT,
  input  logic        CFG_WE,
  input  logic [5:0]  CFG_IDX,
  input  logic [31:0] CFG_NUM_INST,
  input  logic [31:0] CFG_ANS,
  input  logic        START,
  input  logic        CLEAR,
  output logic [1:0]  STATE,
  output logic [5:0]  FAIL_IDX,
  output logic [31:0] FAIL_VALUE,
  output logic [5:0]  PASS_CNT,
  output logic [31:0] CYCLE
);

  localparam logic [6:0] NUM_TEST_W = 7'(NUM_TEST);

  chk_state_e  state_q,     state_d;
  logic [31:0] cycle_q,     cycle_d;
  logic [5:0]  passCnt_q,   passCnt_d;
  logic [5:0]  failIdx_q,   failIdx_d;
  logic [31:0] failValue_q, failValue_d;

  logic       tableWe;
  logic       clrPassed;
  logic       chkEn;
  logic       anyMismatch;
  logic [5:0] mismatchIdx;
  logic [5:0] matchCnt;

  assign tableWe   = (state_q == ST_IDLE) && CFG_WE && ({1'b0, CFG_IDX} < NUM_TEST_W);
  assign clrPassed = (state_q == ST_IDLE) && START;
  assign chkEn     = (state_q == ST_RUN);

  riscv_chk_table #(
    .NUM_TEST (NUM_TEST)
  ) u_table (
    .clk_i         (CLK),
    .rst_ni        (RSTn),
    .wrEn_i        (tableWe),
    .wrIdx_i       (CFG_IDX),
    .wrNumInst_i   (CFG_NUM_INST),
    .wrAns_i       (CFG_ANS),
    .clrPassed_i   (clrPassed),
    .chkEn_i       (chkEn),
    .numInst_i     (NUM_INST),
    .outValue_i    (OUTPUT_PORT),
    .mismatch_o    (anyMismatch),
    .mismatchIdx_o (mismatchIdx),
    .matchCnt_o    (matchCnt)
  );

  // Next-state and counter logic. In RUN the decision order is: mismatch
  // (FAIL with entry index), then HALT (PASS), then timeout (FAIL with the
  // timeout code). The timeout test looks at the registered CYCLE, and CYCLE
  // still counts the RUN cycle in which the timeout is taken, so a run that
  // times out freezes with CYCLE one above TIMEOUT.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    passCnt_d   = passCnt_q;
    failIdx_d   = failIdx_q;
    failValue_d = failValue_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_RUN;
          cycle_d     = '0;
          passCnt_d   = '0;
          failIdx_d   = '0;
          failValue_d = '0;
        end
      end
      ST_RUN: begin
        cycle_d = satInc(cycle_q);
        if (anyMismatch) begin
          state_d     = ST_FAIL;
          failIdx_d   = mismatchIdx;
          failValue_d = OUTPUT_PORT;
        end else begin
          passCnt_d = passCnt_q + matchCnt;
          if (HALT) begin
            state_d = ST_PASS;
          end else if (cycle_q >= TIMEOUT) begin
            state_d     = ST_FAIL;
            failIdx_d   = FAIL_IDX_TIMEOUT;
            failValue_d = OUTPUT_PORT;
          end
        end
      end
      ST_PASS, ST_FAIL: begin
        if (CLEAR) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any run in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      passCnt_q   <= '0;
      failIdx_q   <= '0;
      failValue_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      passCnt_q   <= passCnt_d;
      failIdx_q   <= failIdx_d;
      failValue_q <= failValue_d;
    end
  end

  assign STATE      = state_q;
  assign FAIL_IDX   = failIdx_q;
  assign FAIL_VALUE = failValue_q;
  assign PASS_CNT   = passCnt_q;
  assign CYCLE      = cycle_q;

endmodule
